// File: rtl/hls_run_sequencer.sv
// Repeated start/done sequencer for an HLS accelerator: issues back-to-back runs,
// measures per-run latency with a watchdog, queues results and keeps min/max/total.
module hls_run_sequencer #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned RUN_W      = 16,
    parameter int unsigned TIMEOUT    = 200000000,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned RES_DEPTH  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    input  logic [RUN_W-1:0] num_runs,
    output logic             start_port,
    input  logic             done_port,
    output logic             busy,
    output logic             all_done,
    output logic             timed_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RUN_W-1:0] res_index,
    output logic [CNT_W-1:0] res_cycles,
    output logic             res_status,
    output logic [CNT_W-1:0] min_cycles,
    output logic [CNT_W-1:0] max_cycles,
    output logic [CNT_W-1:0] total_cycles
);

    localparam int unsigned PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int unsigned CW    = PTR_W + 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_LOG, S_GAP, S_DONE
    } state_t;

    state_t           state;
    logic [RUN_W-1:0] runs;
    logic [RUN_W-1:0] run_idx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] result;
    logic             status;
    logic [GAP_W-1:0] gap_cnt;

    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_n;
    logic [CW-1:0]    count, count_n;
    logic [RUN_W-1:0] mem_idx [RES_DEPTH];
    logic [CNT_W-1:0] mem_cyc [RES_DEPTH];
    logic             mem_st  [RES_DEPTH];

    logic             full_c, push_c, pop_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic [CNT_W:0]   sum_c;

    assign full_c    = (count == CW'(RES_DEPTH));
    assign push_c    = (state == S_LOG) && !full_c;
    assign pop_c     = res_valid && res_ready;
    assign cnt_inc_c = cnt + CNT_W'(1);
    assign sum_c     = {1'b0, total_cycles} + {1'b0, result};

    // Sequencer FSM with registered handshake outputs and statistics
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            runs         <= '0;
            run_idx      <= '0;
            cnt          <= '0;
            result       <= '0;
            status       <= 1'b0;
            gap_cnt      <= '0;
            start_port   <= 1'b0;
            busy         <= 1'b0;
            all_done     <= 1'b0;
            timed_out    <= 1'b0;
            min_cycles   <= '1;
            max_cycles   <= '0;
            total_cycles <= '0;
        end else begin
            start_port <= 1'b0;
            all_done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        timed_out <= 1'b0;
                        if (num_runs != '0) begin
                            runs         <= num_runs;
                            run_idx      <= '0;
                            min_cycles   <= '1;
                            max_cycles   <= '0;
                            total_cycles <= '0;
                            busy         <= 1'b1;
                            start_port   <= 1'b1;
                            state        <= S_ISSUE;
                        end else begin
                            all_done <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (done_port) begin
                        result <= CNT_W'(1);
                        status <= 1'b0;
                        state  <= S_LOG;
                    end else if (TIMEOUT_C <= CNT_W'(1)) begin
                        result    <= TIMEOUT_C;
                        status    <= 1'b1;
                        timed_out <= 1'b1;
                        state     <= S_LOG;
                    end else begin
                        cnt   <= CNT_W'(1);
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // cnt_inc_c is the index of the current cycle counted from the start cycle
                    if (done_port) begin
                        result <= cnt_inc_c;
                        status <= 1'b0;
                        state  <= S_LOG;
                    end else if (cnt_inc_c >= TIMEOUT_C) begin
                        result    <= TIMEOUT_C;
                        status    <= 1'b1;
                        timed_out <= 1'b1;
                        state     <= S_LOG;
                    end else begin
                        cnt <= cnt_inc_c;
                    end
                end
                S_LOG: begin
                    if (!full_c) begin
                        if (!status) begin
                            if (result < min_cycles) min_cycles <= result;
                            if (result > max_cycles) max_cycles <= result;
                            total_cycles <= sum_c[CNT_W] ? '1 : sum_c[CNT_W-1:0];
                        end
                        if (status || (run_idx == runs - RUN_W'(1))) begin
                            busy     <= 1'b0;
                            all_done <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            run_idx <= run_idx + RUN_W'(1);
                            if (GAP_CYCLES == 0) begin
                                start_port <= 1'b1;
                                state      <= S_ISSUE;
                            end else begin
                                gap_cnt <= '0;
                                state   <= S_GAP;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        start_port <= 1'b1;
                        state      <= S_ISSUE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Next read pointer and occupancy
    always_comb begin
        rd_ptr_n = rd_ptr;
        count_n  = count;
        if (pop_c) rd_ptr_n = rd_ptr + PTR_W'(1);
        case ({push_c, pop_c})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
    end

    // Result FIFO control and registered first-word-fall-through head
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            res_valid  <= 1'b0;
            res_index  <= '0;
            res_cycles <= '0;
            res_status <= 1'b0;
        end else begin
            rd_ptr    <= rd_ptr_n;
            count     <= count_n;
            res_valid <= (count_n != '0);
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            // The new head is the entry being written this cycle when the read pointer lands on it
            if (push_c && (rd_ptr_n == wr_ptr)) begin
                res_index  <= run_idx;
                res_cycles <= result;
                res_status <= status;
            end else begin
                res_index  <= mem_idx[rd_ptr_n];
                res_cycles <= mem_cyc[rd_ptr_n];
                res_status <= mem_st[rd_ptr_n];
            end
        end
    end

    // Result storage
    always_ff @(posedge clock) begin
        if (push_c) begin
            mem_idx[wr_ptr] <= run_idx;
            mem_cyc[wr_ptr] <= result;
            mem_st[wr_ptr]  <= status;
        end
    end

endmodule

// File: tb/tb_hls_run_sequencer.sv
// Directed bench for hls_run_sequencer: accelerator stub, sequence-level result model,
// per-cycle pop scoreboard and protocol monitor.
module tb_hls_run_sequencer;

    localparam int unsigned CNT_W      = 32;
    localparam int unsigned RUN_W      = 16;
    localparam int unsigned TIMEOUT    = 50;
    localparam int unsigned GAP_CYCLES = 2;
    localparam int unsigned RES_DEPTH  = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic             go;
    logic [RUN_W-1:0] num_runs;
    logic             start_port;
    logic             done_port = 1'b0;
    logic             busy, all_done, timed_out, res_valid, res_status;
    logic             res_ready;
    logic [RUN_W-1:0] res_index;
    logic [CNT_W-1:0] res_cycles, min_cycles, max_cycles, total_cycles;

    hls_run_sequencer #(
        .CNT_W(CNT_W), .RUN_W(RUN_W), .TIMEOUT(TIMEOUT),
        .GAP_CYCLES(GAP_CYCLES), .RES_DEPTH(RES_DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .go(go), .num_runs(num_runs),
        .start_port(start_port), .done_port(done_port), .busy(busy),
        .all_done(all_done), .timed_out(timed_out), .res_valid(res_valid),
        .res_ready(res_ready), .res_index(res_index), .res_cycles(res_cycles),
        .res_status(res_status), .min_cycles(min_cycles), .max_cycles(max_cycles),
        .total_cycles(total_cycles)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Per-run accelerator latency (start cycle through done cycle); 0 = never answers
    int lat_tab [16];

    // Expected sequence outcome, derived from latencies alone
    int     exp_idx [16];
    int     exp_cyc [16];
    int     exp_st  [16];
    int     exp_n;
    int     e_starts;
    longint e_min, e_max, e_tot;
    int     e_to;

    task automatic plan(input int n);
        exp_n = 0; e_starts = 0; e_to = 0;
        e_min = 64'hFFFF_FFFF; e_max = 0; e_tot = 0;
        for (int i = 0; i < n; i++) begin
            e_starts++;
            if (lat_tab[i] == 0 || lat_tab[i] > int'(TIMEOUT)) begin
                exp_idx[exp_n] = i; exp_cyc[exp_n] = int'(TIMEOUT); exp_st[exp_n] = 1;
                exp_n++;
                e_to = 1;
                break;
            end
            exp_idx[exp_n] = i; exp_cyc[exp_n] = lat_tab[i]; exp_st[exp_n] = 0;
            exp_n++;
            if (lat_tab[i] < e_min) e_min = lat_tab[i];
            if (lat_tab[i] > e_max) e_max = lat_tab[i];
            e_tot += lat_tab[i];
        end
    endtask

    int seq_id = 0;

    // Accelerator stub: answers each start after the tabled latency
    int acc_seq = 0, acc_idx = 0, acc_wait = 0;
    always @(posedge clock) begin
        #1;
        done_port = 1'b0;
        if (reset || acc_seq != seq_id) begin
            acc_seq = seq_id; acc_idx = 0; acc_wait = 0;
        end
        if (!reset) begin
            if (acc_wait > 0) begin
                acc_wait--;
                if (acc_wait == 0) done_port = 1'b1;
            end
            if (start_port) begin
                if (lat_tab[acc_idx] == 1) done_port = 1'b1;
                else if (lat_tab[acc_idx] > 1) acc_wait = lat_tab[acc_idx] - 1;
                acc_idx++;
            end
        end
    end

    // Monitor: counts pulses, checks busy framing, scoreboards every pop
    int mon_seq = 0;
    int cyc = 0, n_start = 0, n_done = 0, n_pop = 0, viol = 0, start_cyc = 0, done_cyc = 0;
    bit prev_busy = 1'b0;
    always @(negedge clock) begin
        cyc++;
        if (mon_seq != seq_id) begin
            mon_seq = seq_id; n_start = 0; n_done = 0; n_pop = 0; viol = 0;
        end
        if (reset) begin
            prev_busy = 1'b0;
        end else begin
            if (start_port) begin n_start++; start_cyc = cyc; end
            if (all_done)   begin n_done++;  done_cyc = cyc;  end
            if ((start_port && !busy) || (all_done && busy) || (prev_busy && !busy && !all_done))
                viol++;
            prev_busy = busy;
            if (res_valid && res_ready) begin
                if (n_pop >= exp_n) begin
                    chk("unexpected_pop", n_pop, exp_n);
                end else begin
                    chk("res_index",  res_index,  exp_idx[n_pop]);
                    chk("res_cycles", res_cycles, exp_cyc[n_pop]);
                    chk("res_status", res_status, exp_st[n_pop]);
                end
                n_pop++;
            end
        end
    end

    int go_cyc = 0;

    task automatic launch(input int n);
        @(posedge clock); #1;
        seq_id++;
        go = 1'b1;
        num_runs = RUN_W'(n);
        go_cyc = cyc + 1;
        @(posedge clock); #1;
        go = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (n_done == 0 && k < budget) begin
            @(posedge clock);
            k++;
        end
        chk({tag, "_all_done_seen"}, n_done, 1);
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic finish_seq(input string tag, input bit with_stats);
        chk({tag, "_done_pulses"}, n_done, 1);
        chk({tag, "_starts"}, n_start, e_starts);
        chk({tag, "_entries"}, n_pop, exp_n);
        chk({tag, "_busy_protocol"}, viol, 0);
        if (with_stats) begin
            chk({tag, "_min"}, min_cycles, e_min);
            chk({tag, "_max"}, max_cycles, e_max);
            chk({tag, "_total"}, total_cycles, e_tot);
            chk({tag, "_timed_out"}, timed_out, e_to);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_start_port"}, start_port, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_all_done"}, all_done, 0);
        chk({tag, "_timed_out"}, timed_out, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_min"}, min_cycles, 64'hFFFF_FFFF);
        chk({tag, "_max"}, max_cycles, 0);
        chk({tag, "_total"}, total_cycles, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1; go = 1'b0; num_runs = '0; res_ready = 1'b1;
        for (int i = 0; i < 16; i++) lat_tab[i] = 0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_values("rst");
        reset = 1'b0;

        // Three runs of 11 cycles (done 10 cycles after start)
        for (int i = 0; i < 3; i++) lat_tab[i] = 11;
        plan(3); launch(3); wait_done("t1", 300);
        finish_seq("t1", 1'b1);
        chk("t1_min_lit", min_cycles, 11);
        chk("t1_total_lit", total_cycles, 33);

        // Silent accelerator: one timeout entry, remaining runs abandoned
        for (int i = 0; i < 4; i++) lat_tab[i] = 0;
        plan(4); launch(4); wait_done("t2", 300);
        finish_seq("t2", 1'b1);
        chk("t2_start_to_all_done", done_cyc - start_cyc, 51);
        chk("t2_timed_out_lit", timed_out, 1);
        repeat (20) @(posedge clock);
        chk("t2_no_restart", n_start, 1);

        // Done with start, done exactly at the limit, then one cycle too late
        lat_tab[0] = 1; lat_tab[1] = 50; lat_tab[2] = 51;
        plan(3); launch(3); wait_done("t3", 300);
        finish_seq("t3", 1'b1);
        chk("t3_min_lit", min_cycles, 1);
        chk("t3_max_lit", max_cycles, 50);

        // Consumer stalled: two entries fill the FIFO, third result waits in LOG
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) lat_tab[i] = 3;
        plan(4); launch(4);
        repeat (60) @(posedge clock);
        #1;
        chk("t4_stall_starts", n_start, RES_DEPTH + 1);
        chk("t4_stall_busy", busy, 1);
        chk("t4_stall_valid", res_valid, 1);
        chk("t4_stall_no_done", n_done, 0);
        res_ready = 1'b1;
        wait_done("t4", 300);
        finish_seq("t4", 1'b1);

        // Mixed latencies with an ignored go while busy
        lat_tab[0] = 6; lat_tab[1] = 21; lat_tab[2] = 9;
        plan(3); launch(3);
        repeat (5) @(posedge clock);
        #1;
        go = 1'b1; num_runs = RUN_W'(7);
        @(posedge clock); #1;
        go = 1'b0;
        wait_done("t5", 300);
        finish_seq("t5", 1'b1);
        chk("t5_min_lit", min_cycles, 6);
        chk("t5_max_lit", max_cycles, 21);
        chk("t5_total_lit", total_cycles, 36);

        // Zero runs: all_done the cycle after go, nothing issued or logged
        plan(0); launch(0); wait_done("t6", 20);
        finish_seq("t6", 1'b0);
        chk("t6_done_latency", done_cyc - go_cyc, 1);

        // Asynchronous reset during the second run's WAIT with an entry held in the FIFO
        res_ready = 1'b0;
        lat_tab[0] = 4; lat_tab[1] = 30;
        plan(2); launch(2);
        repeat (15) @(posedge clock);
        #1;
        chk("t7_pre_reset_valid", res_valid, 1);
        chk("t7_pre_reset_min", min_cycles, 4);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("t7_async");
        @(posedge clock); #1;
        reset = 1'b0;
        res_ready = 1'b1;
        lat_tab[0] = 4; lat_tab[1] = 4;
        plan(2); launch(2); wait_done("t8", 300);
        finish_seq("t8", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
